mbus_rr: RTL and testbench

MBUS_RR -- requirements
Module: mbus_rr

---
 rtl/mbus_rr.sv | 161 ++++++++++++++++
 tb/tb_mbus_rr.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mbus_rr.sv
// Multi-master bus with round-robin arbitration, 4-bit page decode and one-cycle read return.
// Optional ownership timeout with per-master masking is enabled by defining MBUS_TIMEOUT_EN.
module mbus_rr #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 2,
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_wr,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_dout,
  output logic [NUM_M-1:0]    m_grant,
  output logic [DW-1:0]       m_din,
  output logic [NUM_S-1:0]    s_sel,
  output logic                s_wr,
  output logic [AW-1:0]       s_addr,
  output logic [DW-1:0]       s_din,
  input  logic [NUM_S*DW-1:0] s_dout,
  output logic                dec_err,
  output logic                bus_to,
  output logic                fsm_state
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  // Handshake: m_req is a level held by a master for as long as it wants the bus;
  // m_grant is the registered answer, and the owner's signals pass straight through
  // to the slaves for every cycle its grant bit is high.
  state_t            state;
  logic [IW-1:0]     owner, last, winner;
  logic [NUM_M-1:0]  elig, elig_base, grant_vec;
  logic              found, own, owner_req, page_ok, release_bus, tmo;
  logic [3:0]        page, rd_page;
  logic              rd_pend;
  logic [DW-1:0]     din_q, rd_data;

  assign own       = (state == OWN);
  assign fsm_state = own;

  always_comb begin
    s_wr      = 1'b0;
    s_addr    = '0;
    s_din     = '0;
    owner_req = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (own && owner == IW'(i)) begin
        s_wr      = m_wr[i];
        s_addr    = m_addr[i*AW +: AW];
        s_din     = m_dout[i*DW +: DW];
        owner_req = m_req[i];
      end
    end
  end

  assign page    = s_addr[AW-1 -: 4];
  assign page_ok = (int'(page) < NUM_S);

  always_comb begin
    s_sel   = '0;
    rd_data = '0;
    for (int j = 0; j < NUM_S; j++) begin
      s_sel[j] = own && (page == 4'(j));
      if (rd_page == 4'(j)) rd_data = s_dout[j*DW +: DW];
    end
  end

  // The slave answers in the cycle after the address; that cycle passes its data
  // through and also captures it, so m_din then holds until the next read.
  assign m_din = rd_pend ? rd_data : din_q;

  // Round-robin search starts just after the last owner; the current owner is never
  // its own successor, which matters only when it is being revoked by timeout.
  always_comb begin
    elig  = elig_base;
    found = 1'b0;
    winner = last;
    for (int i = 0; i < NUM_M; i++) begin
      if (own && owner == IW'(i)) elig[i] = 1'b0;
    end
    for (int k = 1; k <= NUM_M; k++) begin
      if (!found && elig[(int'(last) + k) % NUM_M]) begin
        found  = 1'b1;
        winner = IW'((int'(last) + k) % NUM_M);
      end
    end
    for (int i = 0; i < NUM_M; i++) grant_vec[i] = (winner == IW'(i));
  end

  assign release_bus = own && (!owner_req || tmo);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      m_grant <= '0;
      owner   <= '0;
      last    <= IW'(NUM_M - 1);
      dec_err <= 1'b0;
      rd_page <= '0;
      rd_pend <= 1'b0;
      din_q   <= '0;
    end else begin
      dec_err <= own && !page_ok;
      rd_pend <= 1'b0;
      if (rd_pend) din_q <= rd_data;
      if (own && !s_wr) begin
        if (page_ok) begin
          rd_page <= page;
          rd_pend <= 1'b1;
        end else begin
          din_q <= '0;
        end
      end
      if (!own || release_bus) begin
        if (found) begin
          state   <= OWN;
          owner   <= winner;
          last    <= winner;
          m_grant <= grant_vec;
        end else begin
          state   <= IDLE;
          m_grant <= '0;
        end
      end
    end
  end

`ifdef MBUS_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0]    to_cnt;
  logic [NUM_M-1:0] mask;

  assign tmo       = own && (to_cnt == CW'(TO_CYCLES - 1));
  assign elig_base = m_req & ~mask;

  // A revoked master stays masked until it lowers its request at least once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      mask   <= '0;
      bus_to <= 1'b0;
    end else begin
      bus_to <= tmo;
      mask   <= (mask & m_req) | (tmo ? m_grant : '0);
      to_cnt <= (own && !release_bus) ? to_cnt + 1'b1 : '0;
    end
  end
`else
  // Ownership is unlimited; the comparison is constant false for any legal limit.
  assign tmo       = (TO_CYCLES < 0);
  assign elig_base = m_req;
  assign bus_to    = 1'b0;
`endif

endmodule

// File: tb/tb_mbus_rr.sv
// Directed bench for mbus_rr (4 masters, 2 slaves): arbitration order, routing,
// read return, page errors, asynchronous reset and ownership limit.
module tb_mbus_rr;

  localparam int NUM_M = 4;
  localparam int NUM_S = 2;
  localparam int AW    = 16;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NUM_M-1:0]    m_req, m_wr;
  logic [NUM_M*AW-1:0] m_addr;
  logic [NUM_M*DW-1:0] m_dout;
  logic [NUM_M-1:0]    m_grant;
  logic [DW-1:0]       m_din;
  logic [NUM_S-1:0]    s_sel;
  logic                s_wr;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_din;
  logic [NUM_S*DW-1:0] s_dout;
  logic                dec_err, bus_to, fsm_state;

  logic [31:0] exp_q[$];
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;

  mbus_rr #(.NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .TO_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
    .m_dout(m_dout), .m_grant(m_grant), .m_din(m_din), .s_sel(s_sel), .s_wr(s_wr),
    .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .dec_err(dec_err),
    .bus_to(bus_to), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) passed++;
      else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic drive_m0(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    m_wr[0]       = wr;
    m_addr[15:0]  = addr;
    m_dout[31:0]  = data;
  endtask

  logic [NUM_M-1:0] g_exp;
  logic             bad_seen;

  initial begin
    reset_n = 1'b0;
    m_req   = '0;
    m_wr    = '0;
    m_addr  = '0;
    m_dout  = '0;
    s_dout  = '0;
    repeat (2) @(posedge clk);
    #1;
    push(32'h0); check("rst_grant",   32'(m_grant));
    push(32'h0); check("rst_sel",     32'(s_sel));
    push(32'h0); check("rst_din",     m_din);
    push(32'h0); check("rst_dec_err", 32'(dec_err));
    push(32'h0); check("rst_bus_to",  32'(bus_to));
    push(32'h0); check("rst_state",   32'(fsm_state));

    // release with two requesters: master 0 first, then direct handover
    m_req = 4'b0011;
    @(negedge clk) reset_n = 1'b1;
    step(); push(32'h1); check("first_grant", 32'(m_grant));
    m_req = 4'b0010;
    step(); push(32'h2); check("handover", 32'(m_grant));
    m_req = 4'b0000;
    step(); push(32'h0); check("to_idle_grant", 32'(m_grant));
    push(32'h0); check("to_idle_state", 32'(fsm_state));

    // fresh reset, then rotation with all requesting and one-cycle tenures
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    m_req = 4'hF;
    g_exp = 4'b0001;
    step(); push(32'(g_exp)); check("rr_0", 32'(m_grant));
    for (int k = 1; k <= 4; k++) begin
      m_req = 4'hF & ~g_exp;
      g_exp = {g_exp[NUM_M-2:0], g_exp[NUM_M-1]};
      step(); push(32'(g_exp)); check($sformatf("rr_%0d", k), 32'(m_grant));
    end
    m_req = 4'b0000;
    step(); push(32'h0); check("rr_idle", 32'(m_grant));

    // master 0 reads, reads, writes, then accesses unmapped pages
    s_dout = {32'hCAFE_F00D, 32'h1234_5678};
    m_req  = 4'b0001;
    step(); push(32'h1); check("m0_grant", 32'(m_grant));
    drive_m0(1'b0, 16'h0010, 32'h0);
    #1;
    push(32'h1);    check("rd0_sel",  32'(s_sel));
    push(32'h0);    check("rd0_wr",   32'(s_wr));
    push(32'h0010); check("rd0_addr", 32'(s_addr));
    step(); push(32'h1234_5678); check("rd0_data", m_din);
    drive_m0(1'b0, 16'h1000, 32'h0);
    #1; push(32'h2); check("rd1_sel", 32'(s_sel));
    step(); push(32'hCAFE_F00D); check("rd1_data", m_din);
    drive_m0(1'b1, 16'h1004, 32'hDEAD_BEEF);
    #1;
    push(32'h2);           check("wr_sel",  32'(s_sel));
    push(32'h1);           check("wr_wr",   32'(s_wr));
    push(32'hDEAD_BEEF);   check("wr_din",  s_din);
    push(32'h1004);        check("wr_addr", 32'(s_addr));
    push(32'hCAFE_F00D);   check("wr_din_hold", m_din);
    step();
    s_dout[63:32] = 32'h0;
    #1;
    push(32'hCAFE_F00D); check("din_hold_after_wr", m_din);
    push(32'h0);         check("wr_no_dec_err", 32'(dec_err));
    drive_m0(1'b0, 16'hF000, 32'h0);
    #1; push(32'h0); check("unmap_rd_sel", 32'(s_sel));
    step();
    push(32'h1); check("unmap_rd_dec_err", 32'(dec_err));
    push(32'h0); check("unmap_rd_din",     m_din);
    drive_m0(1'b1, 16'h2000, 32'h1111_1111);
    #1; push(32'h0); check("unmap_wr_sel", 32'(s_sel));
    step();
    push(32'h1); check("unmap_wr_dec_err", 32'(dec_err));
    push(32'h0); check("unmap_wr_din",     m_din);
    drive_m0(1'b0, 16'h0010, 32'h0);
    step();
    push(32'h0);         check("dec_err_clear", 32'(dec_err));
    push(32'h1234_5678); check("rd_after_err",  m_din);

    // asynchronous reset in the middle of a write
    drive_m0(1'b1, 16'h0004, 32'h0000_0ABC);
    #1; push(32'h1); check("pre_rst_sel", 32'(s_sel));
    #2 reset_n = 1'b0;
    #1;
    push(32'h0); check("async_rst_grant", 32'(m_grant));
    push(32'h0); check("async_rst_sel",   32'(s_sel));
    push(32'h0); check("async_rst_din",   m_din);
    #1 reset_n = 1'b1;
    m_req = 4'b0000;
    m_wr  = '0;

    // master 1 holds the bus while master 0 waits
    m_req = 4'b0010;
    step(); push(32'h2); check("m1_grant", 32'(m_grant));
    m_req = 4'b0011;
`ifdef MBUS_TIMEOUT_EN
    bad_seen = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (m_grant !== 4'b0010 || bus_to !== 1'b0) bad_seen = 1'b1;
    end
    push(32'h0); check("to_held_15", 32'(bad_seen));
    step();
    push(32'h1); check("to_grant_m0", 32'(m_grant));
    push(32'h1); check("to_pulse",    32'(bus_to));
    step();
    push(32'h0); check("to_pulse_end", 32'(bus_to));
    m_req = 4'b0010;
    step(); push(32'h0); check("m1_masked", 32'(m_grant));
    repeat (3) step();
    push(32'h0); check("m1_still_masked", 32'(m_grant));
    m_req = 4'b0000;
    step();
    m_req = 4'b0010;
    step(); push(32'h2); check("m1_unmasked", 32'(m_grant));
`else
    bad_seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (m_grant !== 4'b0010 || bus_to !== 1'b0) bad_seen = 1'b1;
    end
    push(32'h0); check("unlimited_hold", 32'(bad_seen));
    m_req = 4'b0001;
    step(); push(32'h1); check("after_hold_m0", 32'(m_grant));
`endif
    m_req = 4'b0000;
    step(); push(32'h0); check("final_idle", 32'(m_grant));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
